// File: rtl/mux_rr_reg_if.sv
// mux_rr_reg_if: handshake bundle between N producers, the registered
// mux/arbiter and a single downstream consumer.
//   mode      : 0 = fixed select, 1 = round-robin
//   sel       : channel index used in fixed-select mode
//   in_data   : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, from the mux)
//   out_data  : registered output beat
//   out_ch    : channel that produced out_data
//   out_valid : output register holds a beat
//   out_ready : consumer accepts the beat
// The master modport is the producer/consumer side; the slave modport is the mux.
interface mux_rr_reg_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel registered multiplexer with valid/ready flow control.
// Selects one input channel per cycle, either the channel named by sel
// (mode 0) or by round-robin arbitration over valid channels (mode 1),
// and loads it into a single output register. The register refills in the
// same cycle it drains, so throughput is one beat per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_reg_if slave modport (mode, sel, in_*, out_*)
module mux_rr_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_rr_reg_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_CH);

  // Round-robin pointer advance, wrapping from the last channel back to 0.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] k);
    if (k == SEL_W'(NUM_CH - 1)) return '0;
    return k + SEL_W'(1);
  endfunction

  logic [SEL_W-1:0]  ptr;
  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  ch_p1;
  logic              vld_p1;

  logic              load_en;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_ch;
  logic [WIDTH-1:0]  grant_data;
  logic [NUM_CH-1:0] in_ready;
  int                idx;

  assign load_en = !vld_p1 || bus.out_ready;

  // Stage p0: grant evaluation and input data selection.
  always_comb begin
    grant_vld  = 1'b0;
    grant_ch   = '0;
    grant_data = '0;
    idx        = 0;
    if (!bus.mode) begin
      // sel values beyond the last channel never match, so they grant nothing.
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_ch  = SEL_W'(k);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the channel closest to ptr
      // (in wrap-around order) is the last writer and wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % NUM_CH;
        if (bus.in_valid[IDX_W'(idx)]) begin
          grant_vld = 1'b1;
          grant_ch  = SEL_W'(idx);
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch == SEL_W'(k)) grant_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // in_ready is held low while reset is asserted, even though the empty
  // output register would otherwise make load_en true.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = rst_n && load_en && grant_vld && (grant_ch == SEL_W'(k));
    end
  end

  assign bus.in_ready = in_ready;

  // Stage p1: output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        data_p1 <= grant_data;
        ch_p1   <= grant_ch;
        vld_p1  <= 1'b1;
        if (bus.mode) ptr <= next_ptr(grant_ch);
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed-vector bench for mux_rr_reg (WIDTH=8, NUM_CH=4).
// Inputs are driven 1 time unit after the rising edge; in_ready is sampled
// 2 units after the edge and registered outputs 1 unit after the next edge.
module tb_mux_rr_reg;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux_rr_reg_if #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) bus ();

  mux_rr_reg #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.mode     = 1'b0;
    bus.sel      = 2'd0;
    bus.in_data  = 32'h0;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    vectors++;
    if (bus.out_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_out_data got=%h want=00", bus.out_data);
    end
    vectors++;
    if (bus.out_ch !== 2'd0) begin
      miscompares++; $display("FAIL reset_out_ch got=%0d want=0", bus.out_ch);
    end
    vectors++;
    if (bus.in_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_in_ready got=%b want=0000", bus.in_ready);
    end
    #3 rst_n = 1'b1;
    bus.in_valid = 4'h0;
    tick();
  endtask

  task automatic test_fixed_select();
    logic [7:0] exp_d [4];
    logic [3:0] exp_r [4];
    exp_d = '{8'h00, 8'h04, 8'h09, 8'h06};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.mode      = 1'b0;
    bus.in_data   = {8'h06, 8'h09, 8'h04, 8'h00};
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      vectors++;
      if (bus.in_ready !== exp_r[s]) begin
        miscompares++; $display("FAIL fixed_in_ready sel=%0d got=%b want=%b", s, bus.in_ready, exp_r[s]);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[s] || bus.out_ch !== 2'(s)) begin
        miscompares++;
        $display("FAIL fixed_out sel=%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                 s, bus.out_valid, bus.out_data, bus.out_ch, exp_d[s], s);
      end
    end
  endtask

  task automatic test_fixed_invalid();
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1011;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL fixed_inv_drain got=%b want=0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 4'b0000) begin
      miscompares++; $display("FAIL fixed_inv_in_ready got=%b want=0000", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL fixed_inv_idle got=%b want=0", bus.out_valid);
    end
    bus.in_data[23:16] = 8'hA5;
    bus.in_valid       = 4'b1111;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_ch !== 2'd2) begin
      miscompares++;
      $display("FAIL fixed_inv_load got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  task automatic test_rr_all_valid();
    logic [1:0] ech;
    bus.mode      = 1'b1;
    bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ech = 2'(i % 4);
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== ech || bus.out_data !== (8'h10 + 8'(ech))) begin
        miscompares++;
        $display("FAIL rr_all beat=%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                 i, bus.out_valid, bus.out_data, bus.out_ch, 8'h10 + 8'(ech), ech);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch [6];
    exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1};
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.in_valid = 4'b0010;
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i] || bus.out_data !== (8'h10 + 8'(exp_ch[i]))) begin
        miscompares++;
        $display("FAIL rr_sparse beat=%0d got v=%b d=%h ch=%0d want v=1 ch=%0d",
                 i, bus.out_valid, bus.out_data, bus.out_ch, exp_ch[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    // pointer is 2 here; only ch0 valid so the search wraps to ch0
    bus.in_valid = 4'b0000;
    tick();
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.out_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_load got v=%b d=%h ch=%0d want v=1 d=10 ch=0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.in_data[7:0] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.in_ready !== 4'b0000) begin
        miscompares++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0000", i, bus.in_ready);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.out_ch !== 2'd0) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h ch=%0d want v=1 d=10 ch=0",
                 i, bus.out_valid, bus.out_data, bus.out_ch);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b0001) begin
      miscompares++; $display("FAIL bp_release_in_ready got=%b want=0001", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || bus.out_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_refill got v=%b d=%h ch=%0d want v=1 d=55 ch=0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  task automatic test_reset_midstream();
    // pointer is 1: a ch1 grant moves it to 2, then the beat is stalled
    bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'b0010;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 8'h11) begin
      miscompares++;
      $display("FAIL mid_preload got v=%b d=%h ch=%0d want v=1 d=11 ch=1",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_async got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
    tick();
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 8'h10) begin
      miscompares++;
      $display("FAIL mid_first_grant got v=%b d=%h ch=%0d want v=1 d=10 ch=0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fixed_select();
    test_fixed_invalid();
    test_rr_all_valid();
    test_rr_sparse();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
